// File: rtl/base_ram_arbiter_pkg.sv
// Shared definitions for the BaseRAM arbiter: FSM state encodings, owner
// encoding, SRAM word-address slice and wait-counter width.
package base_ram_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    // Byte address bits that form the 20-bit SRAM word address.
    localparam int SRAM_ADDR_LSB = 2;
    localparam int SRAM_ADDR_MSB = 21;
    localparam int SRAM_ADDR_W   = SRAM_ADDR_MSB - SRAM_ADDR_LSB + 1;

    // Width of the strobe-duration and starvation counters.
    localparam int CNT_W = 3;

    // A phase of N cycles loads N-1 and leaves when the counter reads zero.
    function automatic logic [CNT_W-1:0] cnt_load_val(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/base_ram_arbiter_wait_cnt.sv
// sram_wait_cnt: loadable down-counter with a zero flag. Times the READ and
// WR_PULSE phases of the BaseRAM arbiter.
module sram_wait_cnt
    import base_ram_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_reg;

    // Load has priority; decrement stops at zero so the flag stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/base_ram_arbiter.sv
// base_ram_arbiter: shares the BaseRAM port between instruction fetch (IF)
// and data access (MEM). MEM has fixed priority unless the optional
// starvation guard is built in with `define BASE_RAM_ARB_STARVE_GUARD_EN.
// All SRAM-facing outputs are registered; the tristate lives at the top level.
module base_ram_arbiter
    import base_ram_arbiter_pkg::*;
#(
    parameter int READ_CYCLES  = 1,
    parameter int WRITE_CYCLES = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_be,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic [19:0] sram_addr,
    output logic [3:0]  sram_be_n,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic [31:0] sram_data_o,
    output logic        sram_data_oe,
    input  logic [31:0] sram_data_i
);

    localparam logic [CNT_W-1:0] READ_LOAD  = cnt_load_val(READ_CYCLES);
    localparam logic [CNT_W-1:0] WRITE_LOAD = cnt_load_val(WRITE_CYCLES);

    // Durations outside the counter range cannot be timed correctly.
    generate
        if (READ_CYCLES < 1 || READ_CYCLES > 7) begin : g_bad_read_cycles
            $error("base_ram_arbiter: READ_CYCLES must be in 1..7");
        end
        if (WRITE_CYCLES < 1 || WRITE_CYCLES > 7) begin : g_bad_write_cycles
            $error("base_ram_arbiter: WRITE_CYCLES must be in 1..7");
        end
        if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_starve_limit
            $error("base_ram_arbiter: STARVE_LIMIT must be in 1..7");
        end
    endgenerate

    state_t                 state_reg, state_next;
    owner_t                 owner_reg, owner_next;
    logic                   we_reg, we_next;
    logic [3:0]             be_reg, be_next;
    logic [SRAM_ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]            wdata_reg, wdata_next;

    logic                   cnt_load;
    logic [CNT_W-1:0]       cnt_val;
    logic                   cnt_dec;
    logic                   cnt_zero;
    logic                   grant_if;

    logic                   ce_n_next, oe_n_next, we_n_next, data_oe_next;
    logic [3:0]             be_n_next;
    logic                   if_ack_next, mem_ack_next;

    logic [31:0]            rdata_reg [2];

    // Only the word-address bits reach the SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:22], if_addr[1:0], mem_addr[31:22], mem_addr[1:0]};

    sram_wait_cnt u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

`ifdef BASE_RAM_ARB_STARVE_GUARD_EN
    logic [CNT_W-1:0] starve_reg, starve_next;
    logic             if_forced;

    assign if_forced = (starve_reg >= CNT_W'(STARVE_LIMIT));
    assign grant_if  = if_req && (!mem_req || if_forced);

    // Count MEM grants taken while IF waits; any IF grant or idle IF clears it.
    always_comb begin
        starve_next = starve_reg;
        if (!if_req) begin
            starve_next = '0;
        end else if (state_reg == ST_IDLE) begin
            if (grant_if) begin
                starve_next = '0;
            end else if (mem_req && !if_forced) begin
                starve_next = starve_reg + 1'b1;
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_reg <= '0;
        end else begin
            starve_reg <= starve_next;
        end
    end
`else
    assign grant_if = if_req && !mem_req;
`endif

    // Next-state logic and request latching at grant.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        we_next    = we_reg;
        be_next    = be_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        cnt_dec    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (grant_if) begin
                    owner_next = OWN_IF;
                    we_next    = 1'b0;
                    be_next    = 4'hF;
                    addr_next  = if_addr[SRAM_ADDR_MSB:SRAM_ADDR_LSB];
                    state_next = ST_READ;
                    cnt_load   = 1'b1;
                    cnt_val    = READ_LOAD;
                end else if (mem_req) begin
                    owner_next = OWN_MEM;
                    we_next    = mem_we;
                    be_next    = mem_be;
                    addr_next  = mem_addr[SRAM_ADDR_MSB:SRAM_ADDR_LSB];
                    wdata_next = mem_wdata;
                    if (mem_we) begin
                        state_next = ST_WR_SETUP;
                    end else begin
                        state_next = ST_READ;
                        cnt_load   = 1'b1;
                        cnt_val    = READ_LOAD;
                    end
                end
            end
            ST_READ: begin
                if (cnt_zero) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_WR_SETUP: begin
                state_next = ST_WR_PULSE;
                cnt_load   = 1'b1;
                cnt_val    = WRITE_LOAD;
            end
            ST_WR_PULSE: begin
                if (cnt_zero) begin
                    state_next = ST_WR_HOLD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_WR_HOLD: state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Strobe values for the state being entered, so the pins change with the state.
    always_comb begin
        ce_n_next    = 1'b1;
        oe_n_next    = 1'b1;
        we_n_next    = 1'b1;
        be_n_next    = 4'hF;
        data_oe_next = 1'b0;
        if_ack_next  = 1'b0;
        mem_ack_next = 1'b0;
        case (state_next)
            ST_READ: begin
                ce_n_next = 1'b0;
                oe_n_next = 1'b0;
                be_n_next = 4'h0;
            end
            ST_WR_SETUP, ST_WR_HOLD: begin
                ce_n_next    = 1'b0;
                be_n_next    = ~be_next;
                data_oe_next = 1'b1;
            end
            ST_WR_PULSE: begin
                ce_n_next    = 1'b0;
                we_n_next    = 1'b0;
                be_n_next    = ~be_next;
                data_oe_next = 1'b1;
            end
            ST_DONE: begin
                if_ack_next  = (owner_next == OWN_IF);
                mem_ack_next = (owner_next == OWN_MEM);
            end
            default: begin
            end
        endcase
    end

    // State, latched request and registered SRAM/ack outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= OWN_IF;
            we_reg       <= 1'b0;
            be_reg       <= 4'h0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            sram_addr    <= '0;
            sram_be_n    <= 4'hF;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_data_o  <= '0;
            sram_data_oe <= 1'b0;
            if_ack       <= 1'b0;
            mem_ack      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            we_reg       <= we_next;
            be_reg       <= be_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            sram_addr    <= addr_next;
            sram_be_n    <= be_n_next;
            sram_ce_n    <= ce_n_next;
            sram_oe_n    <= oe_n_next;
            sram_we_n    <= we_n_next;
            sram_data_o  <= wdata_next;
            sram_data_oe <= data_oe_next;
            if_ack       <= if_ack_next;
            mem_ack      <= mem_ack_next;
        end
    end

    // Per-owner read data, captured on the edge that leaves READ and held until
    // that owner's next read.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rdata
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_reg[gi] <= '0;
                end else if (state_reg == ST_READ && cnt_zero && owner_reg == owner_t'(gi)) begin
                    rdata_reg[gi] <= sram_data_i;
                end
            end
        end
    endgenerate

    assign if_rdata  = rdata_reg[OWN_IF];
    assign mem_rdata = rdata_reg[OWN_MEM];

endmodule

// File: tb/tb_base_ram_arbiter.sv
// Testbench for base_ram_arbiter. Two instances: A (READ_CYCLES=1,
// WRITE_CYCLES=1) and B (READ_CYCLES=3, WRITE_CYCLES=2); 'sel' chooses which
// one receives requests and is observed. A word-array SRAM pin model answers
// reads and applies writes; a transaction-level memory model predicts data.
`timescale 1ns/1ps
module tb_base_ram_arbiter;

    localparam int RC_A = 1;
    localparam int WC_A = 1;
    localparam int RC_B = 3;
    localparam int WC_B = 2;
    localparam int STARVE = 4;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        rst, sel, mem_init;
    logic        if_req, mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [31:0] sram_data_i;

    logic        if_req_a, mem_req_a, if_req_b, mem_req_b;
    assign if_req_a  = if_req & ~sel;
    assign mem_req_a = mem_req & ~sel;
    assign if_req_b  = if_req & sel;
    assign mem_req_b = mem_req & sel;

    logic [31:0] if_rdata_a, mem_rdata_a, data_o_a, if_rdata_b, mem_rdata_b, data_o_b;
    logic        if_ack_a, mem_ack_a, ce_n_a, oe_n_a, we_n_a, data_oe_a;
    logic        if_ack_b, mem_ack_b, ce_n_b, oe_n_b, we_n_b, data_oe_b;
    logic [19:0] addr_a, addr_b;
    logic [3:0]  be_n_a, be_n_b;

    base_ram_arbiter #(.READ_CYCLES(RC_A), .WRITE_CYCLES(WC_A), .STARVE_LIMIT(STARVE)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req_a), .if_addr(if_addr), .if_rdata(if_rdata_a), .if_ack(if_ack_a),
        .mem_req(mem_req_a), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata_a), .mem_ack(mem_ack_a),
        .sram_addr(addr_a), .sram_be_n(be_n_a), .sram_ce_n(ce_n_a), .sram_oe_n(oe_n_a),
        .sram_we_n(we_n_a), .sram_data_o(data_o_a), .sram_data_oe(data_oe_a),
        .sram_data_i(sram_data_i)
    );

    base_ram_arbiter #(.READ_CYCLES(RC_B), .WRITE_CYCLES(WC_B), .STARVE_LIMIT(STARVE)) u_dut_slow (
        .clk(clk), .rst(rst),
        .if_req(if_req_b), .if_addr(if_addr), .if_rdata(if_rdata_b), .if_ack(if_ack_b),
        .mem_req(mem_req_b), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata_b), .mem_ack(mem_ack_b),
        .sram_addr(addr_b), .sram_be_n(be_n_b), .sram_ce_n(ce_n_b), .sram_oe_n(oe_n_b),
        .sram_we_n(we_n_b), .sram_data_o(data_o_b), .sram_data_oe(data_oe_b),
        .sram_data_i(sram_data_i)
    );

    // Observed (selected) instance
    logic [31:0] o_if_rdata, o_mem_rdata, o_data_o;
    logic        o_if_ack, o_mem_ack, o_ce_n, o_oe_n, o_we_n, o_data_oe;
    logic [19:0] o_addr;
    logic [3:0]  o_be_n;
    assign o_if_rdata  = sel ? if_rdata_b  : if_rdata_a;
    assign o_mem_rdata = sel ? mem_rdata_b : mem_rdata_a;
    assign o_data_o    = sel ? data_o_b    : data_o_a;
    assign o_if_ack    = sel ? if_ack_b    : if_ack_a;
    assign o_mem_ack   = sel ? mem_ack_b   : mem_ack_a;
    assign o_ce_n      = sel ? ce_n_b      : ce_n_a;
    assign o_oe_n      = sel ? oe_n_b      : oe_n_a;
    assign o_we_n      = sel ? we_n_b      : we_n_a;
    assign o_data_oe   = sel ? data_oe_b   : data_oe_a;
    assign o_addr      = sel ? addr_b      : addr_a;
    assign o_be_n      = sel ? be_n_b      : be_n_a;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h2400_0001;
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    // SRAM pin model (aliases on word address bits [9:0])
    logic [31:0] sram_arr [0:1023];
    always_comb sram_data_i = (!o_ce_n && !o_oe_n) ? sram_arr[o_addr[9:0]] : 32'h0;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) sram_arr[i] <= init_word(i);
        end else if (!o_ce_n && !o_we_n && o_data_oe) begin
            for (int b = 0; b < 4; b++)
                if (!o_be_n[b]) sram_arr[o_addr[9:0]][b*8 +: 8] <= o_data_o[b*8 +: 8];
        end
    end

    // Transaction-level reference memory and expected held read data
    logic [31:0] model_mem [0:1023];
    logic [31:0] last_if, last_mem;
    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~m) | (wd & m);
    endfunction

    // One transaction from a single requester; called and returns at a negedge.
    task automatic xfer(input bit is_if, input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        int rc, wc, lat, ack_at, oe_lo, we_lo, doe_lo, idx, bad_addr, bad_be, other_ack;
        bit is_rd;
        logic [31:0] old_w, new_w, got;
        rc = sel ? RC_B : RC_A;
        wc = sel ? WC_B : WC_A;
        is_rd = is_if || !we;
        lat = is_rd ? rc + 1 : wc + 3;
        idx = int'(addr[11:2]);
        old_w = model_mem[idx];
        new_w = is_rd ? old_w : merge(old_w, wdata, be);
        ack_at = 0; oe_lo = 0; we_lo = 0; doe_lo = 0; bad_addr = 0; bad_be = 0; other_ack = 0;
        got = 32'h0;
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            mem_req = 1'b1; mem_we = we; mem_be = be; mem_addr = addr; mem_wdata = wdata;
        end
        for (int k = 1; k <= 20 && ack_at == 0; k++) begin
            @(negedge clk);
            if (!o_oe_n) oe_lo++;
            if (!o_we_n) we_lo++;
            if (o_data_oe) doe_lo++;
            if (!o_ce_n && o_addr !== addr[21:2]) bad_addr++;
            if (!o_we_n && o_be_n !== ~be) bad_be++;
            if (is_if ? o_mem_ack : o_if_ack) other_ack++;
            if (is_if ? o_if_ack : o_mem_ack) begin
                ack_at = k;
                got = is_if ? o_if_rdata : o_mem_rdata;
            end
            if (k == 1) begin
                // request fields change after grant and must be ignored
                if_addr = $urandom; mem_addr = $urandom; mem_wdata = $urandom;
                mem_be = 4'($urandom); mem_we = 1'($urandom);
            end
        end
        if_req = 1'b0;
        mem_req = 1'b0;
        chk({tag, "_ack_latency"}, 32'(ack_at), 32'(lat));
        chk({tag, "_addr"}, 32'(bad_addr), 32'd0);
        chk({tag, "_other_ack"}, 32'(other_ack), 32'd0);
        if (is_rd) begin
            chk({tag, "_oe_cycles"}, 32'(oe_lo), 32'(rc));
            chk({tag, "_we_cycles"}, 32'(we_lo), 32'd0);
            chk({tag, "_data_oe"}, 32'(doe_lo), 32'd0);
            chk({tag, "_rdata"}, got, old_w);
            if (is_if) last_if = old_w;
            else       last_mem = old_w;
        end else begin
            chk({tag, "_we_cycles"}, 32'(we_lo), 32'(wc));
            chk({tag, "_oe_cycles"}, 32'(oe_lo), 32'd0);
            chk({tag, "_data_oe"}, 32'(doe_lo), 32'(wc + 2));
            chk({tag, "_be_n"}, 32'(bad_be), 32'd0);
            model_mem[idx] = new_w;
        end
        @(negedge clk);
        chk({tag, "_ack_pulse"}, 32'({o_if_ack, o_mem_ack}), 32'd0);
        chk({tag, "_if_rdata_hold"}, o_if_rdata, last_if);
        chk({tag, "_mem_rdata_hold"}, o_mem_rdata, last_mem);
        if (!is_rd) chk({tag, "_sram_word"}, sram_arr[idx], new_w);
        $display("txn %0d %s: %s addr=%08h be=%b data=%08h ack_at=%0d",
                 txn_no, tag, is_if ? "IF rd" : (we ? "MEM wr" : "MEM rd"),
                 addr, be, is_rd ? got : wdata, ack_at);
        txn_no++;
    endtask

    // IF and MEM requested in the same cycle (instance A).
    task automatic both(input bit mwe, input logic [3:0] mbe, input logic [31:0] maddr,
                        input logic [31:0] mwdata, input logic [31:0] iaddr, input string tag);
        int mlat, mack, iack, ce_lo, both_ack, midx;
        logic [31:0] mold, iexp, mgot, igot;
        mlat = mwe ? WC_A + 3 : RC_A + 1;
        midx = int'(maddr[11:2]);
        mold = model_mem[midx];
        if (mwe) model_mem[midx] = merge(mold, mwdata, mbe);
        iexp = model_mem[int'(iaddr[11:2])];
        mack = 0; iack = 0; ce_lo = 0; both_ack = 0; mgot = 0; igot = 0;
        if_req = 1'b1; if_addr = iaddr;
        mem_req = 1'b1; mem_we = mwe; mem_be = mbe; mem_addr = maddr; mem_wdata = mwdata;
        for (int k = 1; k <= 40 && (mack == 0 || iack == 0); k++) begin
            @(negedge clk);
            if (!o_ce_n) ce_lo++;
            if (o_mem_ack && o_if_ack) both_ack++;
            if (o_mem_ack && mack == 0) begin mack = k; mgot = o_mem_rdata; mem_req = 1'b0; end
            if (o_if_ack && iack == 0) begin iack = k; igot = o_if_rdata; if_req = 1'b0; end
        end
        if_req = 1'b0;
        mem_req = 1'b0;
        chk({tag, "_mem_ack_at"}, 32'(mack), 32'(mlat));
        chk({tag, "_if_ack_at"}, 32'(iack), 32'(mlat + RC_A + 2));
        chk({tag, "_ce_cycles"}, 32'(ce_lo), 32'((mwe ? WC_A + 2 : RC_A) + RC_A));
        chk({tag, "_both_ack"}, 32'(both_ack), 32'd0);
        chk({tag, "_if_rdata"}, igot, iexp);
        last_if = iexp;
        if (!mwe) begin
            chk({tag, "_mem_rdata"}, mgot, mold);
            last_mem = mold;
        end
        @(negedge clk);
        $display("txn %0d %s: MEM %s then IF rd, mem_ack_at=%0d if_ack_at=%0d",
                 txn_no, tag, mwe ? "wr" : "rd", mack, iack);
        txn_no++;
    endtask

    initial begin
        int mem_acks, if_at;
        logic [31:0] exp_w, a, d;
        logic [3:0] be;
        int kind;

        sel = 1'b0; rst = 1'b1; mem_init = 1'b1;
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_be = 4'h0;
        if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
        for (int i = 0; i < 1024; i++) model_mem[i] = init_word(i);
        last_if = 32'h0; last_mem = 32'h0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ce_n", 32'(o_ce_n), 32'd1);
        chk("rst_oe_n", 32'(o_oe_n), 32'd1);
        chk("rst_we_n", 32'(o_we_n), 32'd1);
        chk("rst_be_n", 32'(o_be_n), 32'hF);
        chk("rst_data_oe", 32'(o_data_oe), 32'd0);
        chk("rst_addr", 32'(o_addr), 32'd0);
        chk("rst_data_o", o_data_o, 32'd0);
        chk("rst_acks", 32'({o_if_ack, o_mem_ack}), 32'd0);
        chk("rst_rdata", o_if_rdata | o_mem_rdata, 32'd0);
        chk("rst_slow_strobes", 32'({ce_n_b, oe_n_b, we_n_b, data_oe_b}), 32'hE);
        rst = 1'b0; mem_init = 1'b0;
        @(negedge clk);

        // Basic IF read and byte-masked MEM write
        xfer(1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0, "t1_if_read");
        chk("t1_if_rdata_value", o_if_rdata, 32'h2400_0001);
        xfer(1'b0, 1'b1, 4'b0011, 32'h0000_0008, 32'hDEAD_BEEF, "t2_mem_write");
        exp_w = init_word(2);
        chk("t2_bytes01_only", sram_arr[2], {exp_w[31:16], 16'hBEEF});

        // Randomized single-requester traffic, including be=0000 writes
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 2));
            a = $urandom;
            d = $urandom;
            be = (n % 10 == 0) ? 4'h0 : 4'($urandom);
            case (kind)
                0:       xfer(1'b1, 1'b0, 4'hF, a, 32'h0, "rnd_if_rd");
                1:       xfer(1'b0, 1'b0, be, a, d, "rnd_mem_rd");
                default: xfer(1'b0, 1'b1, be, a, d, "rnd_mem_wr");
            endcase
        end

        // Simultaneous requests: MEM first, then IF after one IDLE cycle
        a = $urandom;
        both(1'b1, 4'hF, a, 32'hCAFE_F00D, a, "t3_same_addr");
        both(1'b0, 4'h0, $urandom, 32'h0, $urandom, "t3_rd_rd");

        // Reset during WR_PULSE: strobes drop next cycle and no ack follows
        mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'h0;
        mem_addr = 32'h0000_0100; mem_wdata = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);
        chk("t4_in_pulse_we_n", 32'(o_we_n), 32'd0);
        rst = 1'b1;
        mem_req = 1'b0;
        @(negedge clk);
        chk("t4_rst_we_n", 32'(o_we_n), 32'd1);
        chk("t4_rst_ce_n", 32'(o_ce_n), 32'd1);
        chk("t4_rst_data_oe", 32'(o_data_oe), 32'd0);
        rst = 1'b0;
        last_if = 32'h0; last_mem = 32'h0;
        for (int k = 0; k < 5; k++) begin
            chk("t4_no_ack", 32'({o_if_ack, o_mem_ack}), 32'd0);
            @(negedge clk);
        end
        chk("t4_rdata_cleared", o_if_rdata | o_mem_rdata, 32'd0);
        $display("txn %0d t4_reset_in_pulse: write aborted", txn_no);
        txn_no++;

        // MEM requesting back-to-back while IF waits
        if_req = 1'b1; if_addr = 32'h0000_0020;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0030;
        mem_acks = 0; if_at = -1;
        for (int k = 0; k < 200 && if_at < 0 && mem_acks < 12; k++) begin
            @(negedge clk);
            if (o_mem_ack) mem_acks++;
            if (o_if_ack) begin
                if_at = mem_acks;
                chk("t6_if_rdata", o_if_rdata, model_mem[8]);
                if_req = 1'b0;
            end
        end
        mem_req = 1'b0;
        if_req = 1'b0;
`ifdef BASE_RAM_ARB_STARVE_GUARD_EN
        chk("t6_if_after_mem_grants", 32'(if_at), 32'(STARVE));
        last_if = model_mem[8];
`else
        chk("t6_if_starved", 32'(if_at), 32'hFFFF_FFFF);
        chk("t6_mem_grants", 32'(mem_acks), 32'd12);
`endif
        last_mem = model_mem[12];
        repeat (4) @(negedge clk);
        chk("t6_mem_rdata", o_mem_rdata, last_mem);
        $display("txn %0d t6_starvation: mem_grants=%0d if_granted_after=%0d", txn_no, mem_acks, if_at);
        txn_no++;

        // Slow instance: READ_CYCLES=3, WRITE_CYCLES=2
        sel = 1'b1;
        last_if = 32'h0; last_mem = 32'h0;
        @(negedge clk);
        xfer(1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0, "t5_if_read_rc3");
        xfer(1'b0, 1'b1, 4'b1010, 32'h0000_0044, 32'hA5A5_5A5A, "t5_mem_write_wc2");
        for (int n = 0; n < 10; n++) begin
            kind = int'($urandom_range(0, 2));
            a = $urandom;
            d = $urandom;
            case (kind)
                0:       xfer(1'b1, 1'b0, 4'hF, a, 32'h0, "slow_if_rd");
                1:       xfer(1'b0, 1'b0, 4'($urandom), a, d, "slow_mem_rd");
                default: xfer(1'b0, 1'b1, 4'($urandom), a, d, "slow_mem_wr");
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
